// File: rtl/pe_pkg.sv
// Shared constants, mode encodings and FSM state type for the PE2 issue controller.
package pe_pkg;

    localparam int Q        = 3329;
    localparam int DW       = 12;
    localparam int NTT_LAT  = 8;
    localparam int INTT_LAT = 14;
    localparam int TAG_W    = 8;
    localparam int SW_GAP   = 2;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/pe2_issue_ctrl_if.sv
// Job stream, PE2 operand/result and completion signals for pe2_issue_ctrl.
// PE2_ISSUE_PERF_EN adds the perf_jobs/perf_switch/perf_stall counters.
interface pe2_issue_ctrl_if #(
    parameter int DW    = pe_pkg::DW,
    parameter int TAG_W = pe_pkg::TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [DW-1:0]    in_u;
    logic [DW-1:0]    in_v;
    logic [DW-1:0]    in_w1;
    logic [DW-1:0]    in_w2;
    logic [TAG_W-1:0] in_tag;

    logic             pe_sel;
    logic [DW-1:0]    pe_u;
    logic [DW-1:0]    pe_v;
    logic [DW-1:0]    pe_w1;
    logic [DW-1:0]    pe_w2;
    logic [DW-1:0]    pe_bf_upper;
    logic [DW-1:0]    pe_bf_lower;

    logic             out_valid;
    logic [DW-1:0]    out_upper;
    logic [DW-1:0]    out_lower;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

`ifdef PE2_ISSUE_PERF_EN
    logic [31:0]      perf_jobs;
    logic [15:0]      perf_switch;
    logic [31:0]      perf_stall;
`endif

    modport slave (
        input  in_valid, in_mode, in_u, in_v, in_w1, in_w2, in_tag,
        input  pe_bf_upper, pe_bf_lower,
        output in_ready, pe_sel, pe_u, pe_v, pe_w1, pe_w2,
        output out_valid, out_upper, out_lower, out_tag,
`ifdef PE2_ISSUE_PERF_EN
        output busy, perf_jobs, perf_switch, perf_stall
`else
        output busy
`endif
    );

    modport master (
        output in_valid, in_mode, in_u, in_v, in_w1, in_w2, in_tag,
        output pe_bf_upper, pe_bf_lower,
        input  in_ready, pe_sel, pe_u, pe_v, pe_w1, pe_w2,
        input  out_valid, out_upper, out_lower, out_tag,
`ifdef PE2_ISSUE_PERF_EN
        input  busy, perf_jobs, perf_switch, perf_stall
`else
        input  busy
`endif
    );

endinterface

// File: rtl/pe2_lat_track.sv
// Valid/tag delay line and in-flight counter; completion strobe registered LAT edges after accept.
// No backpressure: one accept and one completion may occur per cycle.
module pe2_lat_track
    import pe_pkg::*;
#(
    parameter int TAG_W    = pe_pkg::TAG_W,
    parameter int NTT_LAT  = pe_pkg::NTT_LAT,
    parameter int INTT_LAT = pe_pkg::INTT_LAT,
    localparam int CW      = $clog2(INTT_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             mode,
    input  logic [TAG_W-1:0] tag,
    output logic             done_vld,
    output logic [TAG_W-1:0] done_tag,
    output logic [CW-1:0]    inflight
);

    logic [INTT_LAT-1:0] vld_sr;
    logic [TAG_W-1:0]    tag_sr [INTT_LAT];
    logic                tap_vld;
    logic [TAG_W-1:0]    tap_tag;

    always_comb begin
        tap_vld = vld_sr[NTT_LAT-1];
        tap_tag = tag_sr[NTT_LAT-1];
        if (mode == MODE_INTT) begin
            tap_vld = vld_sr[INTT_LAT-1];
            tap_tag = tag_sr[INTT_LAT-1];
        end
    end

    // In NTT mode valid bits die at the NTT tap so a later INTT tap never sees a stale job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr   <= '0;
            done_vld <= 1'b0;
            done_tag <= '0;
            inflight <= '0;
            for (int i = 0; i < INTT_LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= accept;
            tag_sr[0] <= tag;
            for (int i = 1; i < INTT_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1] & ((mode == MODE_INTT) || (i < NTT_LAT));
                tag_sr[i] <= tag_sr[i-1];
            end
            done_vld <= tap_vld;
            if (tap_vld) begin
                done_tag <= tap_tag;
            end
            case ({accept, tap_vld})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: rtl/pe2_issue_ctrl.sv
// PE2 butterfly issue controller: one job/cycle per mode, results after NTT_LAT/INTT_LAT edges.
// Mode change stalls in_ready, drains, switches pe_sel, settles SW_GAP cycles; PE2_ISSUE_PERF_EN adds counters.
module pe2_issue_ctrl
    import pe_pkg::*;
#(
    parameter int DW       = pe_pkg::DW,
    parameter int NTT_LAT  = pe_pkg::NTT_LAT,
    parameter int INTT_LAT = pe_pkg::INTT_LAT,
    parameter int TAG_W    = pe_pkg::TAG_W,
    parameter int SW_GAP   = pe_pkg::SW_GAP
) (
    input  logic                clk,
    input  logic                rst,
    pe2_issue_ctrl_if.slave     bus
);

    localparam int CW = $clog2(INTT_LAT + 1);
    localparam int GW = $clog2(SW_GAP + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(SW_GAP - 1);

    state_t        state;
    state_t        state_nxt;
    logic          cur_mode;
    logic          mode_nxt;
    logic          pend_mode;
    logic          pend_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic          open;
    logic          accept;
    logic          mismatch;
    logic [CW-1:0] inflight;
    logic          done_vld;
    logic [TAG_W-1:0] done_tag;

    assign open         = (state == ST_IDLE) || (state == ST_RUN);
    assign bus.in_ready = open && (bus.in_mode == cur_mode) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign mismatch     = open && bus.in_valid && (bus.in_mode != cur_mode);

    always_comb begin
        state_nxt = state;
        mode_nxt  = cur_mode;
        pend_nxt  = pend_mode;
        gap_nxt   = gap_cnt;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (mismatch) begin
                    if (inflight != '0) begin
                        state_nxt = ST_DRAIN;
                        pend_nxt  = bus.in_mode;
                    end else begin
                        state_nxt = ST_SETTLE;
                        mode_nxt  = bus.in_mode;
                        gap_nxt   = GAP_INIT;
                    end
                end else if (accept) begin
                    state_nxt = ST_RUN;
                end else if (inflight == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = ST_SETTLE;
                    mode_nxt  = pend_mode;
                    gap_nxt   = GAP_INIT;
                end
            end
            ST_SETTLE: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_mode  <= MODE_NTT;
            pend_mode <= MODE_NTT;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cur_mode  <= mode_nxt;
            pend_mode <= pend_nxt;
            gap_cnt   <= gap_nxt;
        end
    end

    // Operands are presented to PE2 only in the cycle after their accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pe_u  <= '0;
            bus.pe_v  <= '0;
            bus.pe_w1 <= '0;
            bus.pe_w2 <= '0;
        end else begin
            bus.pe_u  <= accept ? bus.in_u  : '0;
            bus.pe_v  <= accept ? bus.in_v  : '0;
            bus.pe_w1 <= accept ? bus.in_w1 : '0;
            bus.pe_w2 <= accept ? bus.in_w2 : '0;
        end
    end

    pe2_lat_track #(
        .TAG_W    (TAG_W),
        .NTT_LAT  (NTT_LAT),
        .INTT_LAT (INTT_LAT)
    ) u_trk (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .mode     (cur_mode),
        .tag      (bus.in_tag),
        .done_vld (done_vld),
        .done_tag (done_tag),
        .inflight (inflight)
    );

    assign bus.pe_sel    = cur_mode;
    assign bus.out_valid = done_vld;
    assign bus.out_tag   = done_tag;
    assign bus.out_upper = bus.pe_bf_upper;
    assign bus.out_lower = bus.pe_bf_lower;
    assign bus.busy      = (state != ST_IDLE) || (inflight != '0);

`ifdef PE2_ISSUE_PERF_EN
    logic [31:0] perf_jobs_q;
    logic [15:0] perf_switch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_jobs_q   <= '0;
            perf_switch_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (accept && (perf_jobs_q != '1)) begin
                perf_jobs_q <= perf_jobs_q + 32'd1;
            end
            if ((mode_nxt != cur_mode) && (perf_switch_q != '1)) begin
                perf_switch_q <= perf_switch_q + 16'd1;
            end
            if (bus.in_valid && !bus.in_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_jobs   = perf_jobs_q;
    assign bus.perf_switch = perf_switch_q;
    assign bus.perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_pe2_issue_ctrl.sv
// Directed bench for pe2_issue_ctrl with a behavioural PE2 stub (mod-q butterfly, per-mode latency).
module tb_pe2_issue_ctrl;

    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe2_issue_ctrl_if #(.DW(12), .TAG_W(8)) ifc ();

    pe2_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // PE2 stub: NTT upper=u+v*w1, lower=u-v*w1; INTT upper=u+v, lower=(u-v)*w2 (all mod Q).
    logic [11:0] m_up [14];
    logic [11:0] m_lo [14];

    function automatic logic [11:0] f_up(input logic sel, input logic [11:0] u, v, w1);
        int a, b, t;
        a = {20'd0, u}; b = {20'd0, v}; t = ({20'd0, w1} * b) % Q;
        return sel ? 12'((a + b) % Q) : 12'((a + t) % Q);
    endfunction

    function automatic logic [11:0] f_lo(input logic sel, input logic [11:0] u, v, w1, w2);
        int a, b, t;
        a = {20'd0, u}; b = {20'd0, v}; t = ({20'd0, w1} * b) % Q;
        return sel ? 12'((((a - b + Q) % Q) * {20'd0, w2}) % Q) : 12'((a - t + Q) % Q);
    endfunction

    always @(posedge clk) begin
        m_up[0] <= f_up(ifc.pe_sel, ifc.pe_u, ifc.pe_v, ifc.pe_w1);
        m_lo[0] <= f_lo(ifc.pe_sel, ifc.pe_u, ifc.pe_v, ifc.pe_w1, ifc.pe_w2);
        for (int i = 1; i < 14; i++) begin
            m_up[i] <= m_up[i-1];
            m_lo[i] <= m_lo[i-1];
        end
    end

    assign ifc.pe_bf_upper = ifc.pe_sel ? m_up[13] : m_up[7];
    assign ifc.pe_bf_lower = ifc.pe_sel ? m_lo[13] : m_lo[7];

    // Event log, sampled mid-cycle: accept edge numbers and completions.
    int          acc_q[$];
    int          out_edge_q[$];
    logic [7:0]  out_tag_q[$];
    logic [11:0] out_up_q[$];
    logic [11:0] out_lo_q[$];
    int          stall_meas = 0;
    int          peak = 0;

    always @(negedge clk) begin
        if (rst) begin
            stall_meas = 0;
        end else begin
            if (ifc.in_valid && !ifc.in_ready) stall_meas++;
            if (ifc.in_valid && ifc.in_ready) acc_q.push_back(cyc + 1);
            if (ifc.out_valid) begin
                out_edge_q.push_back(cyc);
                out_tag_q.push_back(ifc.out_tag);
                out_up_q.push_back(ifc.out_upper);
                out_lo_q.push_back(ifc.out_lower);
            end
        end
        if (int'(dut.u_trk.inflight) > peak) peak = int'(dut.u_trk.inflight);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a job until accepted; reports stalled cycles and how many of them had pe_sel=0.
    task automatic send(input logic mode, input logic [11:0] u, v, w1, w2, input logic [7:0] tag,
                        output int n_lo, output int n_s0);
        bit ok;
        ok = 1'b0;
        n_lo = 0;
        n_s0 = 0;
        ifc.in_valid = 1'b1;
        ifc.in_mode  = mode;
        ifc.in_u = u; ifc.in_v = v; ifc.in_w1 = w1; ifc.in_w2 = w2;
        ifc.in_tag = tag;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (ifc.in_ready) ok = 1'b1;
            else begin
                n_lo++;
                if (!ifc.pe_sel) n_s0++;
            end
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        chk("send_accepted", 32'(ok), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ab, ob, nlo, ns0, sum_lo, gaps;
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_mode = 1'b0;
        ifc.in_u = '0; ifc.in_v = '0; ifc.in_w1 = '0; ifc.in_w2 = '0; ifc.in_tag = '0;
        idle(3);
        chk("rst_in_ready", 32'(ifc.in_ready), 0);
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        rst = 1'b0;
        idle(1);
        chk("init_pe_sel", 32'(ifc.pe_sel), 0);
        chk("init_busy", 32'(ifc.busy), 0);
        chk("init_out_tag", 32'(ifc.out_tag), 0);
        chk("init_pe_u", 32'(ifc.pe_u), 0);
        chk("init_in_ready", 32'(ifc.in_ready), 1);

        // Single NTT job
        ab = acc_q.size(); ob = out_tag_q.size();
        send(1'b0, 12'h001, 12'h002, 12'h011, 12'h000, 8'h5A, nlo, ns0);
        chk("s1_nostall", nlo, 0);
        idle(20);
        chk("s1_count", out_tag_q.size() - ob, 1);
        if (out_tag_q.size() > ob && acc_q.size() > ab) begin
            chk("s1_lat", out_edge_q[ob] - acc_q[ab], 8);
            chk("s1_tag", 32'(out_tag_q[ob]), 32'h5A);
            chk("s1_upper", 32'(out_up_q[ob]), 32'h023);
            chk("s1_lower", 32'(out_lo_q[ob]), 32'hCE0);
        end

        // Mode switch from idle to INTT
        ab = acc_q.size(); ob = out_tag_q.size();
        send(1'b1, 12'h100, 12'h050, 12'h000, 12'h002, 8'hA5, nlo, ns0);
        chk("s4_stall", nlo, 3);
        chk("s4_sel0_cycles", ns0, 1);
        chk("s4_pe_sel", 32'(ifc.pe_sel), 1);
        idle(20);
        chk("s4_count", out_tag_q.size() - ob, 1);
        if (out_tag_q.size() > ob && acc_q.size() > ab) begin
            chk("s4_lat", out_edge_q[ob] - acc_q[ab], 14);
            chk("s4_upper", 32'(out_up_q[ob]), 32'h150);
            chk("s4_lower", 32'(out_lo_q[ob]), 32'h160);
        end

        // 20 back-to-back INTT jobs
        ab = acc_q.size(); ob = out_tag_q.size();
        sum_lo = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 12'(i), 12'h001, 12'h000, 12'h001, 8'(i), nlo, ns0);
            sum_lo += nlo;
        end
        idle(30);
        chk("s2_ready_held", sum_lo, 0);
        chk("s2_count", out_tag_q.size() - ob, 20);
        chk("s2_peak_inflight", peak, 14);
        if (out_tag_q.size() >= ob + 20 && acc_q.size() > ab) begin
            chk("s2_first_lat", out_edge_q[ob] - acc_q[ab], 14);
            gaps = 0;
            for (int i = 0; i < 20; i++) begin
                chk("s2_tag_order", 32'(out_tag_q[ob+i]), i);
                if (out_edge_q[ob+i] != out_edge_q[ob] + i) gaps++;
            end
            chk("s2_consecutive", gaps, 0);
        end

        // Reset in the middle of three NTT jobs
        send(1'b0, 12'h010, 12'h001, 12'h001, 12'h000, 8'h70, nlo, ns0);
        chk("s5_switch_stall", nlo, 3);
        send(1'b0, 12'h011, 12'h001, 12'h001, 12'h000, 8'h71, nlo, ns0);
        send(1'b0, 12'h012, 12'h001, 12'h001, 12'h000, 8'h72, nlo, ns0);
        idle(4);
        chk("s5_busy_before", 32'(ifc.busy), 1);
        rst = 1'b1;
        #1;
        chk("s5_rst_out_valid", 32'(ifc.out_valid), 0);
        chk("s5_rst_busy", 32'(ifc.busy), 0);
        chk("s5_rst_out_tag", 32'(ifc.out_tag), 0);
        chk("s5_rst_in_ready", 32'(ifc.in_ready), 0);
        idle(2);
        rst = 1'b0;
        ob = out_tag_q.size();
        idle(25);
        chk("s5_no_stale", out_tag_q.size() - ob, 0);
        chk("s5_busy_after", 32'(ifc.busy), 0);

        // Mode switch under load: 5 NTT then an INTT job
        ab = acc_q.size(); ob = out_tag_q.size();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 12'(i + 1), 12'h001, 12'h001, 12'h000, 8'(8'h30 + i), nlo, ns0);
        end
        send(1'b1, 12'h020, 12'h010, 12'h000, 12'h001, 8'h40, nlo, ns0);
        chk("s3_stall", nlo, 11);
        chk("s3_sel0_cycles", ns0, 9);
        idle(30);
        chk("s3_count", out_tag_q.size() - ob, 6);
        if (out_tag_q.size() >= ob + 6 && acc_q.size() >= ab + 6) begin
            for (int i = 0; i < 5; i++) chk("s3_ntt_tag", 32'(out_tag_q[ob+i]), 32'h30 + i);
            chk("s3_intt_tag", 32'(out_tag_q[ob+5]), 32'h40);
            chk("s3_ntt_lat", out_edge_q[ob+4] - acc_q[ab+4], 8);
            chk("s3_switch_gap", acc_q[ab+5] - out_edge_q[ob+4], 4);
            chk("s3_intt_lat", out_edge_q[ob+5] - acc_q[ab+5], 14);
            chk("s3_ntt_upper", 32'(out_up_q[ob]), 32'h002);
            chk("s3_intt_upper", 32'(out_up_q[ob+5]), 32'h030);
        end
        chk("s3_pe_sel", 32'(ifc.pe_sel), 1);

`ifdef PE2_ISSUE_PERF_EN
        chk("perf_jobs", ifc.perf_jobs, 6);
        chk("perf_switch", 32'(ifc.perf_switch), 1);
        chk("perf_stall_meas", stall_meas, 11);
        chk("perf_stall", ifc.perf_stall, stall_meas);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
